// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1, PC-2, shift schedule, key typedefs and FSM states.
package des_pkg;

  typedef logic [1:28] half_t;
  typedef logic [1:48] subkey_t;
  typedef logic [1:64] key_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd15;

  // Entries are 1-based bit positions into the 64-bit key (bit 1 = MSB).
  localparam logic [6:0] PC1 [1:56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // Entries are 1-based bit positions into the 56-bit {C,D} word.
  localparam logic [5:0] PC2 [1:48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_pc2.sv
// Permuted Choice 2: selects the 48 subkey bits from the rotated {C,D} halves.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] subkey
);

  // Pure bit selection through the PC-2 table.
  always_comb begin
    subkey = 48'd0;
    for (int i = 1; i <= 48; i++) begin
      subkey[i] = cd[PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 64-bit key in, 16 registered round subkeys out under a
// valid/ready handshake, K1..K16 for encryption or K16..K1 for decryption.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int DEC_SUPPORT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [1:48] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy
);

  localparam bit DEC_EN = (DEC_SUPPORT != 0);

  state_t      state_r, next_state_s;
  half_t       c_r, d_r, next_c_s, next_d_s;
  half_t       c0_s, d0_s;
  logic [1:56] pc1_s;
  logic [1:56] next_cd_s;
  subkey_t     pc2_s;
  subkey_t     subkey_r;
  logic [3:0]  round_r, next_round_s;
  logic        dir_r, next_dir_s;
  logic        valid_r, next_valid_s;
  logic        last_r, next_last_s;
  logic        key_ready_r, busy_r;

  function automatic half_t rotl28(input half_t x, input logic [1:0] amt);
    half_t r;
    case (amt)
      2'd1:    r = {x[2:28], x[1]};
      2'd2:    r = {x[3:28], x[1:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic half_t rotr28(input half_t x, input logic [1:0] amt);
    half_t r;
    case (amt)
      2'd1:    r = {x[28], x[1:27]};
      2'd2:    r = {x[27:28], x[1:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  // PC-1 drops the parity bits and splits the key into C0/D0.
  always_comb begin
    pc1_s = 56'd0;
    for (int i = 1; i <= 56; i++) begin
      pc1_s[i] = key_in[PC1[i]];
    end
  end

  assign c0_s      = pc1_s[1:28];
  assign d0_s      = pc1_s[29:56];
  assign next_cd_s = {next_c_s, next_d_s};

  // The subkey register is always PC-2 of the C/D value being loaded this edge.
  des_pc2 u_pc2 (
    .cd     (next_cd_s),
    .subkey (pc2_s)
  );

  // Next-state and next C/D/round computation.
  always_comb begin
    next_state_s = state_r;
    next_c_s     = c_r;
    next_d_s     = d_r;
    next_dir_s   = dir_r;
    next_round_s = round_r;
    next_valid_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (key_valid) begin
          next_dir_s   = DEC_EN ? decrypt : 1'b0;
          next_round_s = 4'd0;
          next_valid_s = 1'b1;
          next_state_s = ST_RUN;
          if (DEC_EN && decrypt) begin
            next_c_s = c0_s;
            next_d_s = d0_s;
          end else begin
            next_c_s = rotl28(c0_s, 2'd1);
            next_d_s = rotl28(d0_s, 2'd1);
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (valid_r && subkey_ready) begin
          if (round_r == LAST_ROUND) begin
            next_valid_s = 1'b0;
            next_state_s = ST_IDLE;
          end else begin
            next_round_s = round_r + 4'd1;
            // Decrypt walks the encrypt shift schedule backwards with right rotations.
            if (DEC_EN && dir_r) begin
              next_c_s = rotr28(c_r, SHIFT[LAST_ROUND - round_r]);
              next_d_s = rotr28(d_r, SHIFT[LAST_ROUND - round_r]);
            end else begin
              next_c_s = rotl28(c_r, SHIFT[round_r + 4'd1]);
              next_d_s = rotl28(d_r, SHIFT[round_r + 4'd1]);
            end
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_valid_s = 1'b0;
      end
    endcase
    next_last_s = next_valid_s & (next_round_s == LAST_ROUND);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r         <= 28'd0;
      d_r         <= 28'd0;
      dir_r       <= 1'b0;
      round_r     <= 4'd0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      subkey_r    <= 48'd0;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      c_r         <= next_c_s;
      d_r         <= next_d_s;
      dir_r       <= next_dir_s;
      round_r     <= next_round_s;
      valid_r     <= next_valid_s;
      last_r      <= next_last_s;
      subkey_r    <= pc2_s;
      key_ready_r <= (next_state_s == ST_IDLE);
      busy_r      <= (next_state_s == ST_RUN);
    end
  end

  assign key_ready    = key_ready_r;
  assign busy         = busy_r;
  assign subkey       = subkey_r;
  assign subkey_round = round_r;
  assign subkey_last  = last_r;
  assign subkey_valid = valid_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized self-checking bench for des_key_schedule against an arithmetic DES key-schedule model.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic [1:64] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [1:48] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_last;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] exp_ks [16];
  logic [47:0] got_ks [16];

  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .subkey_last  (subkey_last),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Textbook schedule: 1-based bit n of a [63:0] word lives at index 64-n.
  task automatic compute_model(input logic [63:0] key);
    logic [27:0] c, d;
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = (c << sh_t[r]) | (c >> (28 - sh_t[r]));
      d = (d << sh_t[r]) | (d >> (28 - sh_t[r]));
      cd = {c, d};
      for (int j = 0; j < 48; j++) exp_ks[r][47-j] = cd[56-pc2_t[j]];
    end
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 (or at a negedge when aborting).
  task automatic run_key(input logic [63:0] key, input logic dec, input bit bp,
                         input bit pulse, input int abort_at);
    int got, cycles;
    bit stalled;
    logic [47:0] held_key;
    logic [3:0] held_round;
    logic [47:0] e;
    compute_model(key);
    key_in = key;
    decrypt = dec;
    key_valid = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    check_eq("key_ready_idle", key_ready, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_in = {$urandom, $urandom};
    got = 0;
    cycles = 0;
    stalled = 0;
    while (got < 16 && cycles < 400) begin
      subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse && cycles == 2) begin
        key_valid = 1'b1;
        key_in = key ^ 64'hFFFF0000FFFF0000;
        decrypt = ~dec;
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("key_ready_run", key_ready, 0);
      check_eq("busy_run", busy, 1);
      check_eq("valid_run", subkey_valid, 1);
      if (stalled) begin
        check_eq("stall_subkey", subkey, held_key);
        check_eq("stall_round", subkey_round, held_round);
      end
      if (subkey_valid && subkey_ready) begin
        e = dec ? exp_ks[15-got] : exp_ks[got];
        got_ks[got] = subkey;
        check_eq("subkey", subkey, e);
        check_eq("round", subkey_round, got[3:0]);
        check_eq("last", subkey_last, (got == 15) ? 1 : 0);
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_key = subkey;
        held_round = subkey_round;
      end
      if (abort_at >= 0 && got == abort_at) return;
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("handshake_count", got, 16);
    key_valid = 1'b0;
    subkey_ready = 1'b0;
    @(negedge clk);
    check_eq("key_ready_after", key_ready, 1);
    check_eq("valid_after", subkey_valid, 0);
    check_eq("busy_after", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check_eq("rst_key_ready", key_ready, 1);
    check_eq("rst_valid", subkey_valid, 0);
    check_eq("rst_subkey", subkey, 0);
    check_eq("rst_round", subkey_round, 0);
    check_eq("rst_last", subkey_last, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_in = 64'd0;
    decrypt = 1'b0;
    key_valid = 1'b0;
    subkey_ready = 1'b0;
    #12;
    check_reset_values();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer encrypt and decrypt.
    run_key(64'h133457799BBCDFF1, 1'b0, 0, 0, -1);
    check_eq("kat_enc_r0", got_ks[0], 48'h1B02EFFC7072);
    check_eq("kat_enc_r1", got_ks[1], 48'h79AED9DBC9E5);
    check_eq("kat_enc_r15", got_ks[15], 48'hCB3D8B0E17F5);
    run_key(64'h133457799BBCDFF1, 1'b1, 0, 0, -1);
    check_eq("kat_dec_r0", got_ks[0], 48'hCB3D8B0E17F5);
    check_eq("kat_dec_r14", got_ks[14], 48'h79AED9DBC9E5);
    check_eq("kat_dec_r15", got_ks[15], 48'h1B02EFFC7072);

    // Backpressure on both directions.
    run_key(64'h133457799BBCDFF1, 1'b0, 1, 0, -1);
    check_eq("bp_enc_r0", got_ks[0], 48'h1B02EFFC7072);
    run_key(64'h0E329232EA6D0D73, 1'b1, 1, 0, -1);

    // Key offered while running must be ignored.
    run_key(64'h0E329232EA6D0D73, 1'b0, 0, 1, -1);

    // Reset in the middle of a schedule, then a fresh key.
    run_key(64'h133457799BBCDFF1, 1'b0, 0, 0, 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_round_seen", 64'(got_ks[6]), 64'(exp_ks[6]));
    check_reset_values();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    subkey_ready = 1'b1;
    @(posedge clk);
    #1;
    run_key(64'h0E329232EA6D0D73, 1'b0, 0, 0, -1);

    // Parity bits must not matter: model of the base key is the reference.
    run_key(64'h133457799BBCDFF1 ^ 64'h0101010101010101, 1'b0, 0, 0, -1);
    check_eq("parity_r0", got_ks[0], 48'h1B02EFFC7072);
    run_key(64'h123456789ABCDEF0, 1'b0, 0, 0, -1);
    run_key(64'h123456789ABCDEF0 ^ 64'h0101010101010101, 1'b1, 1, 0, -1);

    // Random keys, directions and stall patterns.
    for (int t = 0; t < 12; t++) begin
      run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
